// File: rtl/overdrive_inverse.sv
// Inverse of the Q12 soft-clip: largest x in [-One, One-1] with f(x) <= y, by bisection.
// Latency: result valid STEPS cycles after the accept edge; one bisection step per clock.
// Backpressure: in_ready low while busy; the result is held in DONE until out_ready.
module overdrive_inverse #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 12,
    parameter int STEPS = 13
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_sample,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] ou_sample
);

    localparam int CW = $clog2(STEPS + 1);
    localparam logic [CW-1:0]           LAST    = CW'(STEPS - 1);
    localparam logic signed [WIDTH-1:0] ONE     = WIDTH'(1) << FRAC;
    localparam logic signed [WIDTH-1:0] UNIT    = WIDTH'(1);
    localparam logic signed [WIDTH-1:0] THREE   = WIDTH'(3);
    localparam logic signed [WIDTH-1:0] FOUR    = WIDTH'(4);
    localparam logic signed [WIDTH-1:0] LO_INIT = -ONE;
    localparam logic signed [WIDTH-1:0] HI_INIT = ONE - UNIT;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                  state;
    logic signed [WIDTH-1:0] y_reg;
    logic signed [WIDTH-1:0] lo;
    logic signed [WIDTH-1:0] hi;
    logic [CW-1:0]           cnt;

    logic signed [WIDTH-1:0] mid;
    logic signed [WIDTH-1:0] f_mid;
    logic                    take;

    // Soft-clip transfer; signed division truncates toward zero, and all
    // intermediates stay well inside WIDTH bits for |x| <= One.
    function automatic logic signed [WIDTH-1:0] clip_f(input logic signed [WIDTH-1:0] x);
        logic signed [WIDTH-1:0] m;
        logic signed [WIDTH-1:0] c;
        m = (x * x) / ONE;
        c = (m * x) / ONE;
        return (c + x * THREE) / FOUR;
    endfunction

    // Upper-middle probe point so that lo = mid always makes progress.
    always_comb begin
        mid   = lo + ((hi - lo + UNIT) >>> 1);
        f_mid = clip_f(mid);
        take  = (f_mid <= y_reg);
    end

    // Control FSM with bisection datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            ou_sample <= '0;
            y_reg     <= '0;
            lo        <= '0;
            hi        <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state    <= SEARCH;
                        in_ready <= 1'b0;
                        y_reg    <= in_sample;
                        lo       <= LO_INIT;
                        hi       <= HI_INIT;
                        cnt      <= '0;
                    end
                end
                SEARCH: begin
                    if (take) begin
                        lo <= mid;
                    end else begin
                        hi <= mid - UNIT;
                    end
                    cnt <= cnt + CW'(1);
                    // Final step: the interval collapses to one point, which is the result.
                    if (cnt == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        ou_sample <= take ? mid : lo;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_overdrive_inverse.sv
// Randomized bench for overdrive_inverse against a linear-scan reference.
// Checks reset state, latency, directed values, back-pressure and mid-search reset.
// Drives inputs 1 time unit after rising edges and samples there too.
module tb_overdrive_inverse;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] in_sample;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] ou_sample;

    int checks = 0;
    int errors = 0;
    int ftab [0:8191];

    overdrive_inverse #(.WIDTH(32), .FRAC(12), .STEPS(13)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sample (in_sample),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ou_sample (ou_sample)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation still running at 5 ms, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Clip function straight from its definition (SV int division truncates toward zero).
    function automatic int ref_f(input int x);
        int m;
        int c;
        m = (x * x) / 4096;
        c = (m * x) / 4096;
        return (c + 3 * x) / 4;
    endfunction

    // Reference inverse: scan downward for the first x whose clip value fits under y.
    function automatic int ref_inv(input int y);
        for (int x = 4095; x >= -4096; x--) begin
            if (ftab[x + 4096] <= y) return x;
        end
        return -4096;
    endfunction

    task automatic run_one(input int y, input int stall, output int res);
        int waitc;
        int lat;
        waitc = 0;
        while (!in_ready && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
        end
        check_eq("in_ready_before_accept", int'(in_ready), 1);
        in_valid  = 1'b1;
        in_sample = y;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("latency", lat, 13);
        res = ou_sample;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check_eq("stall_hold", ou_sample, res);
            check_eq("stall_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("out_valid_drop", int'(out_valid), 0);
    endtask

    initial begin
        int res;
        int res2;
        int lat;
        int seen;
        int y;
        int fails_sweep;

        for (int x = -4096; x <= 4095; x++) ftab[x + 4096] = ref_f(x);

        rst = 1'b1; in_valid = 1'b0; in_sample = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_eq("reset_in_ready", int'(in_ready), 1);
        check_eq("reset_out_valid", int'(out_valid), 0);
        check_eq("reset_ou_sample", ou_sample, 0);

        // Directed values with their hand-derived answers.
        run_one(0, 0, res);     check_eq("y0", res, 1);
        run_one(1, 2, res);     check_eq("y1", res, 2);
        run_one(-1, 1, res);    check_eq("ym1", res, -2);
        run_one(4094, 0, res);  check_eq("y4094", res, 4095);
        run_one(5000, 3, res);  check_eq("y5000", res, 4095);
        run_one(-4096, 0, res); check_eq("ym4096", res, -4096);
        run_one(-5000, 1, res); check_eq("ym5000", res, -4096);

        // Back-pressure: a new request during a 20-cycle stall must wait for the handshake.
        in_valid = 1'b1; in_sample = 4094;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        check_eq("bp_latency", lat, 13);
        res = ou_sample;
        check_eq("bp_result", res, 4095);
        in_valid = 1'b1; in_sample = 1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check_eq("bp_hold", ou_sample, res);
            check_eq("bp_valid_hold", int'(out_valid), 1);
            check_eq("bp_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("bp_in_ready_after", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        check_eq("bp_second_latency", lat, 13);
        check_eq("bp_second_result", ou_sample, 2);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset in the middle of a search discards the pending result.
        in_valid = 1'b1; in_sample = 0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("mid_rst_in_ready", int'(in_ready), 1);
        check_eq("mid_rst_out_valid", int'(out_valid), 0);
        check_eq("mid_rst_ou_sample", ou_sample, 0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check_eq("mid_rst_no_pulse", seen, 0);
        run_one(0, 0, res2);
        check_eq("after_rst_y0", res2, 1);

        // Sweep across and beyond the range with random strides and output stalls.
        fails_sweep = 0;
        y = -5000;
        while (y <= 5000) begin
            run_one(y, $urandom_range(0, 3), res);
            check_eq("sweep_ref", res, ref_inv(y));
            if (y >= -4096 && res >= -4096 && res <= 4095) begin
                check_eq("sweep_f_le_y", int'(ftab[res + 4096] <= y), 1);
            end
            if (y == 5000) break;
            y = y + $urandom_range(1, 9);
            if (y > 5000) y = 5000;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
